myproject_dense_accum: RTL

Accumulates a fixed number of signed 32-bit products from the upstream 14s×18s multiplier into one dense/conv neuron output. Adds a per-neuron bias, rounds, optionally applies ReLU, saturates to the 16-bit activation format, and hands the result downstream. Sits between the multiplier bank and the next layer's input buffer. Uses valid/ready handshakes on both sides.

---
 rtl/myproject_accum_pkg.sv | 23 ++
 rtl/myproject_round_sat.sv | 40 ++++
 rtl/myproject_dense_accum.sv | 115 +++++++++++
 3 files changed

// File: rtl/myproject_accum_pkg.sv
// Shared constants, FSM encoding and width rule for the dense/conv neuron accumulator.
// The width rule keeps a full group of worst-case products plus bias from overflowing the accumulator.
package myproject_accum_pkg;

    localparam int DEF_PROD_WIDTH = 32;
    localparam int DEF_N_TERMS    = 9;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_SHIFT      = 10;
    localparam int DEF_OUT_WIDTH  = 16;

    localparam int DEF_ACC_WIDTH_MIN = DEF_PROD_WIDTH + $clog2(DEF_N_TERMS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    function automatic bit acc_width_ok(input int prod_w, input int n_terms, input int acc_w);
        return acc_w >= prod_w + $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Round-half-up right shift, optional ReLU, then saturation to the activation width.
// Purely combinational; sat_o flags a result that was clipped.
module myproject_round_sat #(
    parameter int ACC_WIDTH = 40,
    parameter int SHIFT     = 10,
    parameter int OUT_WIDTH = 16,
    parameter bit RELU      = 1'b0
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o
);

    // One guard bit so adding the rounding half can never wrap.
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF  = SW'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAX_V = SW'({(OUT_WIDTH-1){1'b1}});
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic signed [SW-1:0] sum_c;
    logic signed [SW-1:0] rnd_c;

    always_comb begin
        sum_c  = {acc_i[ACC_WIDTH-1], acc_i} + HALF;
        rnd_c  = sum_c >>> SHIFT;
        if (RELU && rnd_c[SW-1]) begin
            rnd_c = '0;
        end
        sat_o  = 1'b0;
        data_o = rnd_c[OUT_WIDTH-1:0];
        if (rnd_c > MAX_V) begin
            data_o = MAX_V[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (rnd_c < MIN_V) begin
            data_o = MIN_V[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/myproject_dense_accum.sv
// Sums N_TERMS products plus bias into one activation; result valid 1 cycle after the last term.
// prod_ready drops only while a result is held; the result stays stable until out_ready.
module myproject_dense_accum
    import myproject_accum_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int N_TERMS    = DEF_N_TERMS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter bit RELU       = 1'b0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    input  logic signed [PROD_WIDTH-1:0] bias,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat
);

    if (!acc_width_ok(PROD_WIDTH, N_TERMS, ACC_WIDTH) || (N_TERMS < 1) || (N_TERMS > 255) ||
        (SHIFT < 1) || (SHIFT >= PROD_WIDTH)) begin : g_param_err
        $error("myproject_dense_accum: illegal parameter set");
    end

    localparam int              CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;

    logic signed [ACC_WIDTH-1:0] term_c, base_c, sum_c;
    logic signed [OUT_WIDTH-1:0] rs_data;
    logic                        rs_sat;
    logic                        fire;
    logic                        last_term;

    assign prod_ready = ap_rst_n && (state_q != EMIT);
    assign fire       = prod_valid && prod_ready;

    // The first term of a group starts from bias instead of the running sum.
    assign term_c    = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign base_c    = (state_q == IDLE) ? {{(ACC_WIDTH-PROD_WIDTH){bias[PROD_WIDTH-1]}}, bias} : acc_q;
    assign sum_c     = base_c + term_c;
    assign last_term = (state_q == IDLE) ? (N_TERMS == 1) : (cnt_q == LAST_CNT);

    myproject_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH),
        .RELU      (RELU)
    ) u_round_sat (
        .acc_i  (sum_c),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (fire) begin
                    acc_d = sum_c;
                    cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
                    if (last_term) begin
                        state_d    = EMIT;
                        out_data_d = rs_data;
                        out_sat_d  = rs_sat;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
